// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction-fetch responder with preloadable array, in-order FIFO and configurable read latency.
// Optional random stall injection is enabled by defining INST_MEM_RESPONDER_STALL_EN.
module inst_mem_responder #(
    parameter int inst_width     = 32,
    parameter int addr_width     = 32,
    parameter int mem_words_log2 = 10,
    parameter int fifo_depth     = 2,
    parameter int read_latency   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ir_addr_valid,
    output logic                      ir_addr_ready,
    input  logic [addr_width-1:0]     ir_addr,
    output logic                      ir_data_valid,
    input  logic                      ir_data_ready,
    output logic [inst_width-1:0]     ir_data,
    input  logic                      load_en,
    input  logic [mem_words_log2-1:0] load_addr,
    input  logic [inst_width-1:0]     load_data,
    output logic                      misaligned
);
    localparam int pw = fifo_depth > 1 ? $clog2(fifo_depth) : 1;
    localparam int nw = $clog2(fifo_depth + 1);
    localparam int cw = read_latency > 1 ? $clog2(read_latency) : 1;
    localparam logic [cw-1:0] reload = cw'(read_latency - 1);
    localparam logic [nw-1:0] full_n = nw'(fifo_depth);
    localparam logic [pw-1:0] last_p = pw'(fifo_depth - 1);

    logic [inst_width-1:0]     mem_q [2**mem_words_log2];
    logic [inst_width-1:0]     fifo_q [fifo_depth];
    logic [pw-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic [nw-1:0]             occ_q, occ_d;
    logic [cw-1:0]             lat_q, lat_d;
    logic                      ready_q, ready_d, valid_q, valid_d, mis_q;
    logic [inst_width-1:0]     data_q, data_d, rd_word, head_d;
    logic [mem_words_log2-1:0] idx;
    logic                      push, pop, stall_rdy, stall_lat, unused_addr;

    assign unused_addr = ^ir_addr;
    assign idx         = ir_addr[mem_words_log2+1:2];
    assign rd_word     = mem_q[idx];
    assign push        = ir_addr_valid && ready_q;
    assign pop         = valid_q && ir_data_ready;

`ifdef INST_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall_rdy = lfsr_d[0];
    assign stall_lat = lfsr_q[1];
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else lfsr_q <= lfsr_d;
    end
`else
    assign stall_rdy = 1'b0;
    assign stall_lat = 1'b0;
`endif

    always_comb begin
        wr_d    = push ? (wr_q == last_p ? '0 : wr_q + pw'(1)) : wr_q;
        rd_d    = pop ? (rd_q == last_p ? '0 : rd_q + pw'(1)) : rd_q;
        occ_d   = occ_q + nw'(push) - nw'(pop);
        lat_d   = ((pop && occ_d != '0) || (push && occ_q == '0)) ? reload :
                  (lat_q != '0 && !stall_lat) ? lat_q - cw'(1) : lat_q;
        // A word pushed this cycle is not in fifo_q yet; forward it when it becomes head.
        head_d  = (push && rd_d == wr_q) ? rd_word : fifo_q[rd_d];
        valid_d = lat_d == '0 && occ_d != '0;
        data_d  = valid_d ? head_d : data_q;
        ready_d = occ_d != full_n && !stall_rdy;
    end

    always_ff @(posedge clock) begin
        if (load_en) mem_q[load_addr] <= load_data;
        if (push) fifo_q[wr_q] <= rd_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            lat_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            lat_q   <= lat_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            mis_q   <= mis_q | (push && ir_addr[1:0] != 2'b00);
        end
    end

    assign ir_addr_ready = ready_q;
    assign ir_data_valid = valid_q;
    assign ir_data       = data_q;
    assign misaligned    = mis_q;
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: directed checks of inst_mem_responder with latency 1 (dut a) and latency 3 (dut b).
module tb_inst_mem_responder;
    logic        clock = 1'b0, reset = 1'b1;
    logic        a_avalid = 0, a_aready, a_dvalid, a_dready = 0, a_mis;
    logic [31:0] a_addr = 0, a_data;
    logic        b_avalid = 0, b_aready, b_dvalid, b_dready = 0, b_mis;
    logic [31:0] b_addr = 0, b_data;
    logic        load_en = 0;
    logic [9:0]  load_addr = 0;
    logic [31:0] load_data = 0;
    int          n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    inst_mem_responder #(.read_latency(1)) dut_a (
        .clock(clock), .reset(reset),
        .ir_addr_valid(a_avalid), .ir_addr_ready(a_aready), .ir_addr(a_addr),
        .ir_data_valid(a_dvalid), .ir_data_ready(a_dready), .ir_data(a_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .misaligned(a_mis)
    );

    inst_mem_responder #(.read_latency(3)) dut_b (
        .clock(clock), .reset(reset),
        .ir_addr_valid(b_avalid), .ir_addr_ready(b_aready), .ir_addr(b_addr),
        .ir_data_valid(b_dvalid), .ir_data_ready(b_dready), .ir_data(b_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .misaligned(b_mis)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] d);
        load_en = 1; load_addr = 10'(i); load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        load(0, 32'h13); load(1, 32'h11); load(2, 32'h22); load(3, 32'h33); load(5, 32'h55);
        n_cmp++; if (a_aready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", a_aready); end
        n_cmp++; if (a_dvalid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", a_dvalid); end
        n_cmp++; if (a_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", a_data); end
        n_cmp++; if (a_mis !== 1'b0) begin n_bad++; $display("FAIL rst_mis: got %b want 0", a_mis); end
        n_cmp++; if (b_aready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_b: got %b want 0", b_aready); end
        reset = 0;
        tick();
        n_cmp++; if (a_aready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b want 1", a_aready); end
        n_cmp++; if (b_aready !== 1'b1) begin n_bad++; $display("FAIL rel_ready_b: got %b want 1", b_aready); end
        n_cmp++; if (a_dvalid !== 1'b0) begin n_bad++; $display("FAIL rel_valid: got %b want 0", a_dvalid); end
    endtask

    task automatic test_single_fetch;
        a_dready = 1; a_addr = 0; a_avalid = 1;
        tick();
        a_avalid = 0;
        n_cmp++; if (a_dvalid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", a_dvalid); end
        n_cmp++; if (a_data !== 32'h13) begin n_bad++; $display("FAIL single_data: got %h want 13", a_data); end
        tick();
        n_cmp++; if (a_dvalid !== 1'b0) begin n_bad++; $display("FAIL single_drop: got %b want 0", a_dvalid); end
        n_cmp++; if (a_data !== 32'h13) begin n_bad++; $display("FAIL single_hold: got %h want 13", a_data); end
    endtask

    task automatic test_backpressure;
        a_dready = 0; a_addr = 4; a_avalid = 1;
        tick();
        n_cmp++; if (a_data !== 32'h11 || a_dvalid !== 1'b1) begin n_bad++; $display("FAIL bp_first: got %h/%b want 11/1", a_data, a_dvalid); end
        a_addr = 8;
        tick();
        n_cmp++; if (a_aready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b want 0", a_aready); end
        a_addr = 12;
        tick();
        n_cmp++; if (a_aready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got %b want 0", a_aready); end
        tick();
        n_cmp++; if (a_data !== 32'h11 || a_dvalid !== 1'b1) begin n_bad++; $display("FAIL bp_stable: got %h/%b want 11/1", a_data, a_dvalid); end
        a_dready = 1;
        tick();
        n_cmp++; if (a_data !== 32'h22 || a_dvalid !== 1'b1) begin n_bad++; $display("FAIL bp_second: got %h/%b want 22/1", a_data, a_dvalid); end
        tick();
        a_avalid = 0;
        n_cmp++; if (a_data !== 32'h33 || a_dvalid !== 1'b1) begin n_bad++; $display("FAIL bp_third: got %h/%b want 33/1", a_data, a_dvalid); end
        tick();
        n_cmp++; if (a_dvalid !== 1'b0 || a_data !== 32'h33) begin n_bad++; $display("FAIL bp_empty: got %h/%b want 33/0", a_data, a_dvalid); end
    endtask

    task automatic test_latency;
        int cyc = 0, first_acc = -1, last_pop = -1, got = 0, sent = 0;
        logic acc, pop, prev_v;
        logic [31:0] exp_w [4];
        exp_w = '{32'h13, 32'h11, 32'h22, 32'h33};
        prev_v = 0; b_dready = 1; b_addr = 0; b_avalid = 1;
        for (int t = 0; t < 80 && got < 4; t++) begin
            acc = b_avalid && b_aready;
            pop = b_dvalid && b_dready;
            if (pop) begin
                n_cmp++; if (b_data !== exp_w[got]) begin n_bad++; $display("FAIL lat_data%0d: got %h want %h", got, b_data, exp_w[got]); end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (first_acc < 0) first_acc = cyc - 1;
                sent++;
                b_addr = 32'(sent * 4);
                b_avalid = sent < 4;
            end
            if (pop) last_pop = cyc - 1;
            if (b_dvalid && !prev_v) begin
                n_cmp++; if (cyc - (got == 0 ? first_acc : last_pop) != 3) begin n_bad++; $display("FAIL lat_delay%0d: got %0d want 3", got, cyc - (got == 0 ? first_acc : last_pop)); end
            end
            prev_v = b_dvalid;
        end
        n_cmp++; if (got != 4) begin n_bad++; $display("FAIL lat_timeout: got %0d words want 4", got); end
        b_avalid = 0;
    endtask

    task automatic test_wrap_misalign;
        a_dready = 1; a_addr = 32'h1004; a_avalid = 1;
        tick();
        a_avalid = 0;
        n_cmp++; if (a_data !== 32'h11 || a_dvalid !== 1'b1) begin n_bad++; $display("FAIL wrap_data: got %h/%b want 11/1", a_data, a_dvalid); end
        n_cmp++; if (a_mis !== 1'b0) begin n_bad++; $display("FAIL wrap_mis: got %b want 0", a_mis); end
        tick();
        a_addr = 32'h2; a_avalid = 1;
        tick();
        a_avalid = 0;
        n_cmp++; if (a_data !== 32'h13) begin n_bad++; $display("FAIL mis_data: got %h want 13", a_data); end
        n_cmp++; if (a_mis !== 1'b1) begin n_bad++; $display("FAIL mis_set: got %b want 1", a_mis); end
        tick(); tick();
        n_cmp++; if (a_mis !== 1'b1) begin n_bad++; $display("FAIL mis_sticky: got %b want 1", a_mis); end
    endtask

    task automatic test_reset_mid;
        a_dready = 0; a_addr = 0; a_avalid = 1;
        tick();
        a_addr = 4;
        tick();
        a_avalid = 0;
        n_cmp++; if (a_dvalid !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %b want 1", a_dvalid); end
        reset = 1;
        tick();
        n_cmp++; if (a_dvalid !== 1'b0 || a_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst: got %h/%b want 0/0", a_data, a_dvalid); end
        n_cmp++; if (a_aready !== 1'b0 || a_mis !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", a_aready, a_mis); end
        reset = 0;
        tick();
        n_cmp++; if (a_aready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", a_aready); end
        tick(); tick();
        n_cmp++; if (a_dvalid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got %b want 0", a_dvalid); end
        a_dready = 1; a_addr = 12; a_avalid = 1;
        tick();
        a_avalid = 0;
        n_cmp++; if (a_data !== 32'h33 || a_dvalid !== 1'b1) begin n_bad++; $display("FAIL mid_fresh: got %h/%b want 33/1", a_data, a_dvalid); end
        tick();
        a_addr = 20; a_avalid = 1;
        load_en = 1; load_addr = 5; load_data = 32'h66;
        tick();
        a_avalid = 0; load_en = 0;
        n_cmp++; if (a_data !== 32'h55) begin n_bad++; $display("FAIL rbw_old: got %h want 55", a_data); end
        tick();
        a_avalid = 1;
        tick();
        a_avalid = 0;
        n_cmp++; if (a_data !== 32'h66) begin n_bad++; $display("FAIL rbw_new: got %h want 66", a_data); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_latency();
        test_wrap_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Synthesizable responder for the CPU instruction-read bus. It sits at the memory end of the i_raddr/i_rdata channels that the CPU core drives.
- Accepts fetch addresses on the address channel.
- Looks them up in an internal word-addressed instruction array.
- Returns instruction words on the data channel in request order, after a configurable latency, with full valid/ready backpressure.
- Used as the instruction memory in the CPU simulation testbench and as the reference responder for bus checkers.

Parameters:
- inst_width, 32, instruction/data word width in bits.
- addr_width, 32, width of the fetch address bus.
- mem_words_log2, 10, log2 of array depth in words; 1024 words by default.
- fifo_depth, 2, maximum outstanding accepted requests; power of 2, at least 1.
- read_latency, 1, cycles from an entry reaching FIFO head to data valid; at least 1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ir_addr_valid  input  1  CPU presents a fetch address.
- ir_addr_ready  output  1  responder can accept an address.
- ir_addr  input  addr_width  byte address of the fetch.
- ir_data_valid  output  1  ir_data holds a returned instruction.
- ir_data_ready  input  1  CPU accepts ir_data.
- ir_data  output  inst_width  returned instruction word.
- load_en  input  1  testbench preload write strobe.
- load_addr  input  mem_words_log2  word index for the preload write.
- load_data  input  inst_width  preload write data.
- misaligned  output  1  sticky flag: an accepted address had ir_addr[1:0] != 0.

Behaviour:
- Reset (reset=1 at a clock edge):
  - Empties the FIFO and clears the latency counter.
  - Drives ir_data_valid=0, ir_data=0, misaligned=0 and ir_addr_ready=0.
  - Leaves the memory array contents unchanged.
  - Reset applied mid-transaction discards all outstanding requests, with no partial response.
- ir_addr_ready is registered. It equals 1 when the FIFO is not full, otherwise 0. It is 1 in the first cycle after reset deasserts. It has no combinational path from any input.
- Address handshake:
  - A transfer occurs on a clock edge where ir_addr_valid && ir_addr_ready.
  - The word index is ir_addr[mem_words_log2+1:2]. Address bits above it are ignored, so addressing wraps modulo the array size.
  - The array word is read at acceptance and pushed into the FIFO with the request.
- Load port:
  - load_en writes load_data at load_addr on the clock edge.
  - If a load and an acceptance hit the same word in the same cycle, the accepted request captures the old contents (read-before-write).
  - Loads are honoured during reset.
- Latency counter:
  - Loads read_latency-1 when a new entry becomes FIFO head, or when a push lands in an empty FIFO.
  - Decrements each cycle while nonzero.
  - When it is 0 and the FIFO is non-empty, ir_data_valid is asserted and ir_data is the head word.
  - Minimum accept-to-valid latency is read_latency cycles: with read_latency=1, valid rises in the cycle after acceptance.
- Data handshake:
  - While ir_data_valid=1 and ir_data_ready=0, ir_data_valid and ir_data hold stable.
  - On ir_data_valid && ir_data_ready the head is popped.
  - If another entry remains, the counter reloads. With read_latency=1, back-to-back valid is kept with no bubble.
- Simultaneous push and pop in one cycle: occupancy is unchanged and both happen. Because ready is registered, the full-to-not-full transition frees a slot only from the next cycle.
- Boundaries:
  - Full FIFO: ready is deasserted and ir_addr_valid is ignored.
  - Empty FIFO: ir_data_valid=0 and ir_data holds its last value.
  - ir_data_ready asserted with no valid has no effect.
- misaligned is set on acceptance of an address with ir_addr[1:0] != 0. It is cleared only by reset. The access still proceeds using the truncated word index.
- Ordering: responses are strictly in acceptance order.

Optional Feature:
Macro INST_MEM_RESPONDER_STALL_EN.
- Defined:
  - A 16-bit LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle.
  - When LFSR bit 0 is 1, ir_addr_ready is forced to 0 that cycle.
  - When LFSR bit 1 is 1, the latency counter does not decrement that cycle.
  - This exercises CPU stall paths. Ordering, stability and reset rules are unchanged.
- Not defined: no LFSR logic is built, and timing is exactly as specified above.

Test Plan:
- Reset release: hold reset=1 for 3 cycles, then release → ir_data_valid=0 and ir_addr_ready=0 during reset; ir_addr_ready=1 on the first cycle after release; misaligned=0.
- Single fetch: preload word 0 = 32'h00000013, send ir_addr=0 with ir_data_ready=1, read_latency=1 → ir_data_valid=1 exactly 1 cycle after acceptance, ir_data=32'h00000013, then valid drops.
- Backpressure/full: preload words 1..3 = 32'h11, 32'h22, 32'h33; issue addresses 4, 8, 12 with ir_data_ready=0 → third address stalls (ready=0 after 2 accepts); ir_data=32'h11 stays stable while ready is low; releasing ready returns 32'h11, then 32'h22, then 32'h33 in order.
- Latency/streaming: read_latency=3 with a continuous fetch stream and ir_data_ready=1 → first valid arrives 3 cycles after the first accept; each later word arrives 3 cycles after the previous pop.
- Wrap/misalign: with mem_words_log2=10, fetch 32'h00001004 → returns word 1; fetch 32'h2 → returns word 0 and misaligned=1 until the next reset.
- Reset mid-operation: accept 2 requests, assert reset before any pop → after release no stale ir_data_valid; a new fetch returns fresh data with the correct latency.
